// File: rtl/switch_event_arbiter_if.sv
// rtl/switch_event_arbiter_if.sv - switch inputs and display/status outputs of the event arbiter
interface switch_event_arbiter_if;
    logic [4:0] SW;
    logic [0:6] HEX3;
    logic [0:6] HEX1;
    logic [0:6] HEX0;
    logic [3:0] grant;
    logic [7:0] count_bcd;
    logic       busy;

    modport master (
        output SW,
        input  HEX3, HEX1, HEX0, grant, count_bcd, busy
    );

    modport slave (
        input  SW,
        output HEX3, HEX1, HEX0, grant, count_bcd, busy
    );
endinterface

// File: rtl/switch_event_arbiter.sv
// rtl/switch_event_arbiter.sv - debounced round-robin switch arbiter feeding a BCD counter and 7-seg display
module switch_event_arbiter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  CLOCK_50,
    input  logic                  RST,
    switch_event_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    logic [4:0]           sync_q [SYNC_STAGES];
    logic [4:0]           sync_s;
    logic [3:0][CW-1:0]   cnt_q, cnt_d;
    logic [3:0]           filt_q, filt_d, filt_prev_q;
    logic [3:0]           rise;
    logic [3:0]           pending_q, pending_d;
    logic [1:0]           rr_ptr_q, idx_q, last_idx_q, pick_idx;
    logic                 last_valid_q;
    logic [7:0]           count_q, count_d;
    logic [3:0]           grant_d;
    logic                 busy_d;
    state_t               state_q, state_d;
    logic                 hold;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign hold   = sync_s[4];
    assign rise   = filt_q & ~filt_prev_q;

    // Bring every switch into the clock domain through a plain flop chain
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= bus.SW;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Filtered level flips only after the input disagrees for DEBOUNCE_CYCLES samples in a row
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync_s[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = ~filt_q[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Round-robin search: lowest offset from rr_ptr wins, so scan offsets from high to low
    always_comb begin
        pick_idx = rr_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (pending_q[rr_ptr_q + 2'(k)]) pick_idx = rr_ptr_q + 2'(k);
        end
    end

    // A new rising edge wins over the grant clearing the same pending bit
    always_comb begin
        pending_d = (pending_q & ~grant_d) | rise;
    end

    // Add idx+1 to the two-digit BCD count, wrapping at 100
    always_comb begin
        logic [4:0] ones_sum;
        logic [4:0] tens_sum;
        ones_sum = {1'b0, count_q[3:0]} + {3'b000, idx_q} + 5'd1;
        tens_sum = {1'b0, count_q[7:4]};
        if (ones_sum > 5'd9) begin
            ones_sum = ones_sum - 5'd10;
            tens_sum = tens_sum + 5'd1;
        end
        if (tens_sum > 5'd9) tens_sum = tens_sum - 5'd10;
        count_d = {tens_sum[3:0], ones_sum[3:0]};
    end

    // FSM state register
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: hold only gates the start of a new event
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!hold && pending_q != 4'b0000) state_d = GRANT;
            GRANT:   state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: one-hot grant for the single GRANT cycle, busy outside IDLE
    always_comb begin
        grant_d = 4'b0000;
        busy_d  = (state_q != IDLE);
        if (state_q == GRANT) grant_d = 4'b0001 << pick_idx;
    end

    // Debounce, edge-detect, arbitration and count datapath registers
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            cnt_q        <= '0;
            filt_q       <= '0;
            filt_prev_q  <= '0;
            pending_q    <= '0;
            rr_ptr_q     <= '0;
            idx_q        <= '0;
            last_idx_q   <= '0;
            last_valid_q <= 1'b0;
            count_q      <= 8'h00;
        end else begin
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            pending_q   <= pending_d;
            if (state_q == GRANT) begin
                idx_q    <= pick_idx;
                rr_ptr_q <= pick_idx + 2'd1;
            end
            if (state_q == UPDATE) begin
                count_q      <= count_d;
                last_idx_q   <= idx_q;
                last_valid_q <= 1'b1;
            end
        end
    end

    function automatic logic [0:6] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0001100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign bus.grant     = grant_d;
    assign bus.busy      = busy_d;
    assign bus.count_bcd = count_q;
    assign bus.HEX1      = seg7(count_q[7:4]);
    assign bus.HEX0      = seg7(count_q[3:0]);
    assign bus.HEX3      = last_valid_q ? seg7({2'b00, last_idx_q}) : 7'b1111111;
endmodule

// File: tb/tb_switch_event_arbiter.sv
// tb/tb_switch_event_arbiter.sv - directed table-driven bench for switch_event_arbiter
module tb_switch_event_arbiter;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    switch_event_arbiter_if bus();

    switch_event_arbiter #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
        .CLOCK_50 (clk),
        .RST      (rst),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int gcount = 0;
    logic [3:0] gq[$];
    int         gcq[$];
    int         model_dec;

    typedef struct {
        logic [3:0] mask;
        logic [7:0] exp_bcd;
        int         exp_last;
        int         exp_grants;
    } vec_t;
    vec_t vt[6];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && bus.grant != 4'b0000) begin
            gcount++;
            gq.push_back(bus.grant);
            gcq.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'b0000001;  1: seg = 7'b1001111;
            2: seg = 7'b0010010;  3: seg = 7'b0000110;
            4: seg = 7'b1001100;  5: seg = 7'b0100100;
            6: seg = 7'b0100000;  7: seg = 7'b0001111;
            8: seg = 7'b0000000;  9: seg = 7'b0001100;
            default: seg = 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        to_bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.SW = 5'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        gq.delete();
        gcq.delete();
        model_dec = 0;
    endtask

    task automatic press(input logic [3:0] mask, input logic hold);
        @(negedge clk);
        bus.SW = {hold, mask};
        repeat (12) @(negedge clk);
        bus.SW = {hold, 4'b0000};
        repeat (24) @(negedge clk);
    endtask

    initial begin
        int g0;
        int found;
        int waited;

        vt[0] = '{4'b0100, 8'h03, 2, 1};
        vt[1] = '{4'b0001, 8'h04, 0, 1};
        vt[2] = '{4'b1010, 8'h10, 3, 2};
        vt[3] = '{4'b1111, 8'h20, 3, 4};
        vt[4] = '{4'b0110, 8'h25, 2, 2};
        vt[5] = '{4'b1001, 8'h30, 0, 2};

        bus.SW = 5'b0;
        do_reset();

        // reset state, quiet switches
        repeat (20) @(negedge clk);
        chk("idle_grants", gcount, 0);
        chk("rst_count", bus.count_bcd, 8'h00);
        chk("rst_hex0", bus.HEX0, seg(0));
        chk("rst_hex1", bus.HEX1, seg(0));
        chk("rst_hex3", bus.HEX3, 7'b1111111);
        chk("rst_busy", bus.busy, 0);

        // glitch shorter than debounce window
        bus.SW = 5'b00001;
        repeat (2) @(negedge clk);
        bus.SW = 5'b0;
        repeat (20) @(negedge clk);
        chk("glitch_grants", gcount, 0);
        chk("glitch_count", bus.count_bcd, 8'h00);

        // table of presses, round-robin order visible through HEX3
        for (int r = 0; r < 6; r++) begin
            g0 = gcount;
            press(vt[r].mask, 1'b0);
            chk($sformatf("row%0d_count", r), bus.count_bcd, vt[r].exp_bcd);
            chk($sformatf("row%0d_hex1", r), bus.HEX1, seg(vt[r].exp_bcd[7:4]));
            chk($sformatf("row%0d_hex0", r), bus.HEX0, seg(vt[r].exp_bcd[3:0]));
            chk($sformatf("row%0d_hex3", r), bus.HEX3, seg(vt[r].exp_last));
            chk($sformatf("row%0d_ngrant", r), gcount - g0, vt[r].exp_grants);
            chk($sformatf("row%0d_busy", r), bus.busy, 0);
        end

        // simultaneous rise from reset: ordered grants 3 cycles apart
        do_reset();
        press(4'b1111, 1'b0);
        chk("sim_ngrant", gq.size(), 4);
        if (gq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("sim_grant%0d", i), gq[i], 4'b0001 << i);
                if (i > 0) chk($sformatf("sim_gap%0d", i), gcq[i] - gcq[i-1], 3);
            end
        end
        chk("sim_count", bus.count_bcd, 8'h10);
        chk("sim_hex1", bus.HEX1, 7'b1001111);
        chk("sim_hex0", bus.HEX0, 7'b0000001);
        chk("sim_hex3", bus.HEX3, 7'b0000110);

        // wrap past 99
        do_reset();
        for (int n = 0; n < 9; n++) begin
            press(4'b1111, 1'b0);
            model_dec = (model_dec + 10) % 100;
        end
        for (int n = 0; n < 2; n++) begin
            press(4'b1000, 1'b0);
            model_dec = (model_dec + 4) % 100;
        end
        chk("pre_wrap_count", bus.count_bcd, 8'h98);
        chk("pre_wrap_model", bus.count_bcd, to_bcd(model_dec));
        press(4'b1000, 1'b0);
        chk("wrap_count", bus.count_bcd, 8'h02);
        chk("wrap_hex1", bus.HEX1, 7'b0000001);
        chk("wrap_hex0", bus.HEX0, 7'b0010010);

        // hold suspends grants, release grants, reset mid-UPDATE discards the event
        do_reset();
        press(4'b0001, 1'b0);
        chk("hold_pre_count", bus.count_bcd, 8'h01);
        g0 = gcount;
        press(4'b0010, 1'b1);
        chk("hold_no_grant", gcount - g0, 0);
        chk("hold_busy", bus.busy, 0);
        chk("hold_count", bus.count_bcd, 8'h01);
        bus.SW = 5'b0;
        found = 0;
        waited = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            waited = k + 1;
            if (bus.grant != 4'b0000) begin
                found = 1;
                break;
            end
        end
        chk("hold_release_found", found, 1);
        chk("hold_release_grant", bus.grant, 4'b0010);
        chk("hold_release_latency", (waited <= SYNC + 2), 1);
        @(posedge clk);
        #1;
        chk("update_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_count", bus.count_bcd, 8'h00);
        chk("mid_rst_hex0", bus.HEX0, 7'b0000001);
        chk("mid_rst_hex1", bus.HEX1, 7'b0000001);
        chk("mid_rst_hex3", bus.HEX3, 7'b1111111);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_grant", bus.grant, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_count", bus.count_bcd, 8'h00);
        chk("post_rst_busy", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
